// File: rtl/vga_timing_core.sv
// Parametrised VGA timing generator: H/V counters, registered sync/DE/colour.
// Optional bar test pattern under `VGA_TESTPAT_EN.
module vga_timing_core #(
    parameter int COLOR_W = 8,
    parameter int CNT_W   = 11,
    parameter int H_DISP  = 266,
    parameter int H_FP    = 8,
    parameter int H_SYNC  = 24,
    parameter int H_BP    = 42,
    parameter int V_DISP  = 600,
    parameter int V_FP    = 1,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 22,
    parameter bit HS_POL  = 1'b0,
    parameter bit VS_POL  = 1'b0
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               CE,
    input  logic [COLOR_W-1:0] PIXEL,
    input  logic               TP_SEL,
    output logic [CNT_W-1:0]   X,
    output logic [CNT_W-1:0]   Y,
    output logic               PIXEL_REQ,
    output logic               HSYNC,
    output logic               VSYNC,
    output logic [COLOR_W-1:0] COLOR,
    output logic               DE,
    output logic               FRAME
);

    localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_DISP);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_DISP);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_DISP + H_FP);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_DISP + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_DISP + V_FP);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_DISP + V_FP + V_SYNC);

    logic [CNT_W-1:0]   x_q, x_d, y_q, y_d;
    logic               hs_q, hs_d, vs_q, vs_d;
    logic               de_q, de_d, frame_q, frame_d;
    logic [COLOR_W-1:0] color_q, color_d;
    logic [COLOR_W-1:0] pix_src;
    logic               x_last, y_last, hs_raw, vs_raw;

    assign x_last    = (x_q == H_LAST);
    assign y_last    = (y_q == V_LAST);
    assign hs_raw    = (x_q >= HS_BEG) && (x_q < HS_END);
    assign vs_raw    = (y_q >= VS_BEG) && (y_q < VS_END);
    assign PIXEL_REQ = (x_q < H_ACT) && (y_q < V_ACT);

`ifdef VGA_TESTPAT_EN
    logic [CNT_W+3:0]   bar_div;
    logic [2:0]         bar;
    logic [COLOR_W-1:0] tp_col;

    assign bar_div = {1'b0, x_q, 3'b000} / (CNT_W + 4)'(H_DISP);
    assign bar     = bar_div[2:0];

    // Bar index repeated MSB-first so bar 7 fills all ones at any width
    always_comb begin
        tp_col = '0;
        for (int i = 0; i < COLOR_W; i++) begin
            tp_col[COLOR_W-1-i] = bar[2 - (i % 3)];
        end
    end

    assign pix_src = TP_SEL ? tp_col : PIXEL;
`else
    logic unused_tp_sel;
    assign unused_tp_sel = TP_SEL;
    assign pix_src       = PIXEL;
`endif

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        hs_d    = hs_q;
        vs_d    = vs_q;
        de_d    = de_q;
        color_d = color_q;
        frame_d = 1'b0;
        if (CE) begin
            x_d = x_last ? '0 : x_q + 1'b1;
            if (x_last) begin
                y_d = y_last ? '0 : y_q + 1'b1;
            end
            hs_d    = hs_raw ? HS_POL : ~HS_POL;
            vs_d    = vs_raw ? VS_POL : ~VS_POL;
            de_d    = PIXEL_REQ;
            color_d = PIXEL_REQ ? pix_src : '0;
            frame_d = x_last && y_last;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            x_q     <= '0;
            y_q     <= '0;
            hs_q    <= ~HS_POL;
            vs_q    <= ~VS_POL;
            de_q    <= 1'b0;
            color_q <= '0;
            frame_q <= 1'b0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            de_q    <= de_d;
            color_q <= color_d;
            frame_q <= frame_d;
        end
    end

    assign X     = x_q;
    assign Y     = y_q;
    assign HSYNC = hs_q;
    assign VSYNC = vs_q;
    assign DE    = de_q;
    assign COLOR = color_q;
    assign FRAME = frame_q;

endmodule

// File: tb/tb_vga_timing_core.sv
// Randomised bench for vga_timing_core with a tick-count reference model.
// Small timing: H 4/1/2/1 (total 8), V 3/1/1/1 (total 6).
module tb_vga_timing_core;

    localparam int HT = 8;
    localparam int VT = 6;
`ifdef VGA_TESTPAT_EN
    localparam bit TPEN = 1'b1;
`else
    localparam bit TPEN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ce;
    logic [7:0]  pixel;
    logic        tp_sel;
    logic [10:0] x, y;
    logic        pixel_req, hsync, vsync, de, frame;
    logic [7:0]  color;

    int vectors = 0;
    int miscompares = 0;

    // Reference state: CE ticks since reset plus last registered outputs
    int         mt;
    logic       e_hs, e_vs, e_de, e_frame;
    logic [7:0] e_col;

    always #5 clk = ~clk;

    vga_timing_core #(
        .COLOR_W(8), .CNT_W(11),
        .H_DISP(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_DISP(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut (
        .CLK(clk), .RESET_N(rst_n), .CE(ce), .PIXEL(pixel), .TP_SEL(tp_sel),
        .X(x), .Y(y), .PIXEL_REQ(pixel_req), .HSYNC(hsync), .VSYNC(vsync),
        .COLOR(color), .DE(de), .FRAME(frame)
    );

    function automatic logic [7:0] bar_color(int px);
        logic [2:0] k;
        logic [8:0] r;
        k = 3'((px * 8) / 4);
        r = {k, k, k};
        return r[8:1];
    endfunction

    task automatic model_reset();
        mt      = 0;
        e_hs    = 1'b1;
        e_vs    = 1'b1;
        e_de    = 1'b0;
        e_col   = 8'h00;
        e_frame = 1'b0;
    endtask

    task automatic model_tick(logic c, logic [7:0] p, logic t);
        int px, py;
        logic req;
        if (!c) begin
            e_frame = 1'b0;
            return;
        end
        px      = mt % HT;
        py      = (mt / HT) % VT;
        req     = (px < 4) && (py < 3);
        e_de    = req;
        e_col   = !req ? 8'h00 : ((TPEN && t) ? bar_color(px) : p);
        e_hs    = !(px == 5 || px == 6);
        e_vs    = !(py == 4);
        e_frame = (px == HT - 1) && (py == VT - 1);
        mt++;
    endtask

    function automatic logic [34:0] exp_vec();
        int px, py;
        px = mt % HT;
        py = (mt / HT) % VT;
        return {11'(px), 11'(py), (px < 4) && (py < 3),
                e_hs, e_vs, e_de, e_col, e_frame};
    endfunction

    function automatic logic [34:0] obs_vec();
        return {x, y, pixel_req, hsync, vsync, de, color, frame};
    endfunction

    // Drive one clock with the given inputs; returns at the following negedge
    task automatic cycle(logic c, logic [7:0] p, logic t);
        ce     = c;
        pixel  = p;
        tp_sel = t;
        @(posedge clk);
        model_tick(c, p, t);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        ce     = 1'b1;
        pixel  = 8'hFF;
        tp_sel = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        vectors++;
        if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL reset_state got %h want %h", obs_vec(), exp_vec());
        end
        rst_n = 1'b1;
    endtask

    task automatic test_frame_run();
        int pulses[$];
        for (int n = 1; n <= 100; n++) begin
            cycle(1'b1, (n <= 48) ? 8'hA5 : 8'($urandom), 1'b0);
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL frame_run n=%0d got %h want %h",
                         n, obs_vec(), exp_vec());
            end
            if (frame) pulses.push_back(n);
        end
        vectors++;
        if (pulses.size() != 2 || pulses[0] != 48 || pulses[1] != 96) begin
            miscompares++;
            $display("FAIL frame_period got %0d pulses want 2 at 48,96",
                     pulses.size());
        end
    endtask

    task automatic test_ce_gaps();
        logic pf;
        logic pat[4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        pf  = frame;
        for (int n = 0; n < 200; n++) begin
            cycle(n < 4 ? pat[n] : ($urandom_range(0, 2) != 0),
                  8'($urandom), 1'b0);
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL ce_gap n=%0d got %h want %h",
                         n, obs_vec(), exp_vec());
            end
            vectors++;
            if (frame && pf) begin
                miscompares++;
                $display("FAIL frame_width n=%0d got 2 cycles want 1", n);
            end
            pf = frame;
        end
    endtask

    task automatic test_reset_mid();
        bit found = 0;
        for (int n = 0; n < 100 && !found; n++) begin
            if (mt % (HT * VT) == HT + 2) found = 1;
            else cycle(1'b1, 8'($urandom), 1'b0);
        end
        vectors++;
        if (!found || x !== 11'd2 || y !== 11'd1) begin
            miscompares++;
            $display("FAIL mid_reach got x=%0d y=%0d want 2,1", x, y);
        end
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL mid_reset_async got %h want %h",
                     obs_vec(), exp_vec());
        end
        ce = 1'b1;
        @(negedge clk);
        vectors++;
        if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL mid_reset_hold got %h want %h",
                     obs_vec(), exp_vec());
        end
        rst_n = 1'b1;
        #1;
        vectors++;
        if (x !== 11'd0 || y !== 11'd0) begin
            miscompares++;
            $display("FAIL mid_release got x=%0d y=%0d want 0,0", x, y);
        end
        for (int n = 0; n < 20; n++) begin
            cycle(1'b1, 8'($urandom), 1'b0);
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL post_reset n=%0d got %h want %h",
                         n, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_testpat();
        for (int n = 0; n < 120; n++) begin
            cycle($urandom_range(0, 3) != 0, 8'($urandom), 1'($urandom));
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL testpat n=%0d got %h want %h",
                         n, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame_run();
        test_ce_gaps();
        test_reset_mid();
        test_testpat();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1);
    end

endmodule
